// File: rtl/pwc_pkg.sv
// Shared FSM state encoding for the packet measurement window controller.
package pwc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pwc_state_e;
endpackage

// File: rtl/sat_counter.sv
// Registered accumulator that adds a per-cycle increment and pins at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] cnt
);
  logic [W:0]   w_sum;
  logic [W-1:0] r_cnt;

  // The extra carry bit flags an overflow so the count clamps instead of wrapping.
  assign w_sum = {1'b0, r_cnt} + {1'b0, inc};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= {W{1'b0}};
    end else if (clr) begin
      r_cnt <= {W{1'b0}};
    end else if (en) begin
      r_cnt <= w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/packet_window_ctrl.sv
// Measures good/bad packet counts, byte total and min/max length over a
// start/stop or fixed-length window of clk cycles.
module packet_window_ctrl
  import pwc_pkg::*;
#(
  parameter int CW = 32,
  parameter int BW = 48
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic [CW-1:0] window_len,
  input  logic [15:0]   plen_tdata,
  input  logic          plen_tuser,
  input  logic          plen_tvalid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] good_pkts,
  output logic [CW-1:0] bad_pkts,
  output logic [BW-1:0] total_bytes,
  output logic [15:0]   min_plen,
  output logic [15:0]   max_plen
);
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

  pwc_state_e    r_state;
  pwc_state_e    w_state_next;
  logic          w_start_go;
  logic          w_in_run;
  logic          w_good_en;
  logic          w_bad_en;
  logic          w_stat_clr;
  logic [CW-1:0] r_timer;
  logic [15:0]   r_min_trk;
  logic [15:0]   r_min_plen;
  logic [15:0]   r_max_plen;
  logic [15:0]   w_min_next;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // clear overrides everything; a timer value of 0 means the window only ends on stop.
  always_comb begin
    w_state_next = r_state;
    w_start_go   = 1'b0;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_next = ST_RUN;
            w_start_go   = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_next = ST_DONE;
          end else if (r_timer == C_ONE) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start) begin
            w_state_next = ST_RUN;
            w_start_go   = 1'b1;
          end else begin
            w_state_next = ST_DONE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign w_in_run   = (r_state == ST_RUN) && !clear;
  assign w_good_en  = w_in_run && plen_tvalid && !plen_tuser;
  assign w_bad_en   = w_in_run && plen_tvalid && plen_tuser;
  assign w_stat_clr = clear || w_start_go;
  assign w_min_next = (plen_tdata < r_min_trk) ? plen_tdata : r_min_trk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer <= {CW{1'b0}};
    end else if (clear) begin
      r_timer <= {CW{1'b0}};
    end else if (w_start_go) begin
      r_timer <= window_len;
    end else if ((r_state == ST_RUN) && (r_timer != {CW{1'b0}})) begin
      r_timer <= r_timer - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_DONE);
    end
  end

  // The tracker starts at 0xFFFF; the visible minimum stays 0 until a good packet lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_min_trk  <= 16'hFFFF;
      r_min_plen <= 16'h0000;
      r_max_plen <= 16'h0000;
    end else if (w_stat_clr) begin
      r_min_trk  <= 16'hFFFF;
      r_min_plen <= 16'h0000;
      r_max_plen <= 16'h0000;
    end else if (w_good_en) begin
      r_min_trk  <= w_min_next;
      r_min_plen <= w_min_next;
      r_max_plen <= (plen_tdata > r_max_plen) ? plen_tdata : r_max_plen;
    end
  end

  sat_counter #(.W(CW)) u_good_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (w_stat_clr),
    .en     (w_good_en),
    .inc    (C_ONE),
    .cnt    (good_pkts)
  );

  sat_counter #(.W(CW)) u_bad_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (w_stat_clr),
    .en     (w_bad_en),
    .inc    (C_ONE),
    .cnt    (bad_pkts)
  );

  sat_counter #(.W(BW)) u_byte_acc (
    .clk    (clk),
    .resetn (resetn),
    .clr    (w_stat_clr),
    .en     (w_good_en),
    .inc    ({{(BW-16){1'b0}}, plen_tdata}),
    .cnt    (total_bytes)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign min_plen = r_min_plen;
  assign max_plen = r_max_plen;
endmodule

// File: tb/tb_packet_window_ctrl.sv
// Scoreboard bench for packet_window_ctrl: stimulus queues expected snapshots,
// monitors compare them on each rising done or on an explicit observation strobe.
module tb_packet_window_ctrl;
  typedef struct {
    string       name;
    logic        busy;
    logic        done;
    longint      cyc;
    logic [63:0] good;
    logic [63:0] bad;
    logic [63:0] bytes;
    logic [63:0] mn;
    logic [63:0] mx;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn, start, stop, clear, plen_tuser, plen_tvalid;
  logic [31:0] window_len;
  logic [15:0] plen_tdata;
  logic        busy, done;
  logic [31:0] good_pkts, bad_pkts;
  logic [47:0] total_bytes;
  logic [15:0] min_plen, max_plen;

  logic        start4, stop4, tvalid4;
  logic [15:0] tdata4;
  logic        busy4, done4;
  logic [3:0]  good4, bad4;
  logic [47:0] bytes4;
  logic [15:0] min4, max4;

  exp_t   q[$];
  exp_t   q4[$];
  exp_t   e_m, e_m4;
  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  logic   chk_req = 1'b0;
  logic   done_q  = 1'b0;
  logic   done4_q = 1'b0;

  packet_window_ctrl u_dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .window_len(window_len), .plen_tdata(plen_tdata), .plen_tuser(plen_tuser),
    .plen_tvalid(plen_tvalid), .busy(busy), .done(done), .good_pkts(good_pkts),
    .bad_pkts(bad_pkts), .total_bytes(total_bytes), .min_plen(min_plen), .max_plen(max_plen)
  );

  packet_window_ctrl #(.CW(4), .BW(48)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start4), .stop(stop4), .clear(1'b0),
    .window_len(4'd0), .plen_tdata(tdata4), .plen_tuser(1'b0),
    .plen_tvalid(tvalid4), .busy(busy4), .done(done4), .good_pkts(good4),
    .bad_pkts(bad4), .total_bytes(bytes4), .min_plen(min4), .max_plen(max4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  task automatic check_entry(input exp_t e, input logic b, input logic d, input logic [63:0] g,
                             input logic [63:0] bd, input logic [63:0] by,
                             input logic [63:0] mn, input logic [63:0] mx);
    cmp(e.name, "busy", 64'(b), 64'(e.busy));
    cmp(e.name, "done", 64'(d), 64'(e.done));
    cmp(e.name, "good_pkts", g, e.good);
    cmp(e.name, "bad_pkts", bd, e.bad);
    cmp(e.name, "total_bytes", by, e.bytes);
    cmp(e.name, "min_plen", mn, e.mn);
    cmp(e.name, "max_plen", mx, e.mx);
    if (e.cyc >= 0) cmp(e.name, "done_cycle", 64'(cyc), 64'(e.cyc));
  endtask

  task automatic push(input bit to4, input string nm, input logic b, input logic d, input longint c,
                      input longint g, input longint bd, input longint by, input longint mn, input longint mx);
    exp_t e;
    e.name = nm; e.busy = b; e.done = d; e.cyc = c;
    e.good = 64'(g); e.bad = 64'(bd); e.bytes = 64'(by); e.mn = 64'(mn); e.mx = 64'(mx);
    if (to4) q4.push_back(e);
    else q.push_back(e);
  endtask

  always @(negedge clk) begin
    if ((done && !done_q) || chk_req) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_obs: got an observation, expected none queued");
      end else begin
        e_m = q.pop_front();
        check_entry(e_m, busy, done, 64'(good_pkts), 64'(bad_pkts), 64'(total_bytes),
                    64'(min_plen), 64'(max_plen));
      end
    end
    done_q <= done;
  end

  always @(negedge clk) begin
    if (done4 && !done4_q) begin
      if (q4.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_obs4: got an observation, expected none queued");
      end else begin
        e_m4 = q4.pop_front();
        check_entry(e_m4, busy4, done4, 64'(good4), 64'(bad4), 64'(bytes4),
                    64'(min4), 64'(max4));
      end
    end
    done4_q <= done4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk();
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [31:0] wl);
    window_len = wl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pkt(input logic [15:0] len, input logic user);
    plen_tdata = len;
    plen_tuser = user;
    plen_tvalid = 1'b1;
    tick();
    plen_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q.size() + q4.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    if ((q.size() + q4.size()) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending observations expected 0", q.size() + q4.size());
      q.delete();
      q4.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    window_len = 32'd0; plen_tdata = 16'd0; plen_tuser = 1'b0; plen_tvalid = 1'b0;
    start4 = 1'b0; stop4 = 1'b0; tvalid4 = 1'b0; tdata4 = 16'd0;

    push(1'b0, "reset", 1'b0, 1'b0, -1, 0, 0, 0, 0, 0);
    chk();
    tick();
    resetn = 1'b1;
    tick();

    // Fixed 100-cycle window, done exactly 101 cycles after start.
    push(1'b0, "win100", 1'b0, 1'b1, cyc + 101, 3, 0, 1628, 64, 1500);
    do_start(32'd100);
    pkt(16'd64, 1'b0);
    pkt(16'd1500, 1'b0);
    pkt(16'd64, 1'b0);
    wait_drain(200);

    // Unlimited window closed by stop; packet alongside stop counts, later ones do not.
    push(1'b0, "stop_win", 1'b0, 1'b1, -1, 5, 2, 1050, 50, 400);
    do_start(32'd0);
    pkt(16'd100, 1'b0);
    pkt(16'd200, 1'b0);
    pkt(16'd300, 1'b0);
    pkt(16'd400, 1'b0);
    pkt(16'd999, 1'b1);
    pkt(16'd7, 1'b1);
    stop = 1'b1;
    pkt(16'd50, 1'b0);
    stop = 1'b0;
    wait_drain(20);
    pkt(16'd10, 1'b0);
    pkt(16'd5000, 1'b0);
    pkt(16'd3, 1'b1);
    push(1'b0, "after_stop", 1'b0, 1'b1, -1, 5, 2, 1050, 50, 400);
    chk();

    // Packet in the expiry cycle counts, next one does not; start during RUN ignored.
    push(1'b0, "expiry", 1'b0, 1'b1, cyc + 6, 1, 0, 200, 200, 200);
    do_start(32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    pkt(16'd200, 1'b0);
    pkt(16'd300, 1'b0);
    push(1'b0, "post_expiry", 1'b0, 1'b1, -1, 1, 0, 200, 200, 200);
    chk();

    // clear beats start in DONE; then an empty window leaves min/max at 0.
    window_len = 32'd7;
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    push(1'b0, "clear_start", 1'b0, 1'b0, -1, 0, 0, 0, 0, 0);
    chk();
    push(1'b0, "empty_win", 1'b0, 1'b1, -1, 0, 1, 0, 0, 0);
    do_start(32'd0);
    pkt(16'd77, 1'b1);
    repeat (2) tick();
    pulse_stop();
    wait_drain(20);

    // Asynchronous reset in the middle of a window.
    do_start(32'd0);
    for (int i = 0; i < 7; i++) pkt(16'(100 + i), 1'b0);
    push(1'b0, "mid_run", 1'b1, 1'b0, -1, 7, 0, 721, 100, 106);
    chk();
    resetn = 1'b0;
    push(1'b0, "async_reset", 1'b0, 1'b0, -1, 0, 0, 0, 0, 0);
    chk();
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    push(1'b0, "after_reset", 1'b0, 1'b0, -1, 0, 0, 0, 0, 0);
    chk();

    // Narrow counter instance: 20 good packets saturate good_pkts at 15.
    push(1'b1, "sat_cw4", 1'b0, 1'b1, -1, 15, 0, 200, 10, 10);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tdata4 = 16'd10;
    tvalid4 = 1'b1;
    repeat (20) tick();
    tvalid4 = 1'b0;
    stop4 = 1'b1;
    tick();
    stop4 = 1'b0;
    wait_drain(20);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
